// File: rtl/tx_pkg.sv
// Shared constants and types for the transaction-layer tx path.
package tx_pkg;
    localparam int TX_DATA_W     = 128;
    localparam int TX_KEEP_W     = TX_DATA_W / 8;
    localparam int TX_BYTE_NUM_W = 13;
    localparam int TX_CONN_ID_W  = 4;
    localparam int TX_USER_W     = TX_BYTE_NUM_W + TX_CONN_ID_W;
    localparam int TX_NUM_SRC    = 5;
    localparam int TX_IDX_W      = 3;

    localparam int SRC_BARRIER = 0;
    localparam int SRC_B       = 1;
    localparam int SRC_R       = 2;
    localparam int SRC_AR      = 3;
    localparam int SRC_AW      = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

    function automatic logic [TX_IDX_W-1:0] wrap_inc(input logic [TX_IDX_W-1:0] idx,
                                                     input logic [TX_IDX_W-1:0] last_idx);
        logic [TX_IDX_W-1:0] nxt;
        if (idx == last_idx) begin
            nxt = '0;
        end else begin
            nxt = idx + TX_IDX_W'(1);
        end
        return nxt;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of req scanning upward
// from ptr and wrapping at N.
module rr_pick #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    logic [W:0]   sum_s;
    logic [W-1:0] cand_s;

    // Walk candidates in rotated order; the first requester wins.
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        sum_s  = '0;
        cand_s = '0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, ptr} + (W+1)'(k);
            if (sum_s >= (W+1)'(N)) begin
                cand_s = W'(sum_s - (W+1)'(N));
            end else begin
                cand_s = sum_s[W-1:0];
            end
            if (!found && req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
                idx   = idx;
            end
        end
    end
endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-granular arbiter merging the tx sources into one registered stream:
// strict-priority barrier with a starvation guard, round-robin for the rest.
module tx_pkt_arbiter
    import tx_pkg::*;
#(
    parameter int NUM_SRC    = TX_NUM_SRC,
    parameter int DATA_W     = TX_DATA_W,
    parameter int KEEP_W     = TX_KEEP_W,
    parameter int USER_W     = TX_USER_W,
    parameter int PRIO_IDX   = SRC_BARRIER,
    parameter int STARVE_MAX = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_SRC-1:0]          s_valid,
    output logic [NUM_SRC-1:0]          s_ready,
    input  logic [NUM_SRC*DATA_W-1:0]   s_data,
    input  logic [NUM_SRC*KEEP_W-1:0]   s_keep,
    input  logic [NUM_SRC-1:0]          s_last,
    input  logic [NUM_SRC*USER_W-1:0]   s_user,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic [KEEP_W-1:0]           m_keep,
    output logic                        m_last,
    output logic [USER_W-1:0]           m_user,
    output logic [2:0]                  grant_idx,
    output logic                        busy
);
    localparam int IDX_W = TX_IDX_W;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [NUM_SRC-1:0] PRIO_MASK  = NUM_SRC'(1) << PRIO_IDX;
    localparam logic [IDX_W-1:0]   PRIO_SEL   = IDX_W'(PRIO_IDX);
    localparam logic [IDX_W-1:0]   LAST_SRC   = IDX_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0]   STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [KEEP_W-1:0]   m_keep_q, m_keep_d;
    logic                m_last_q, m_last_d;
    logic [USER_W-1:0]   m_user_q, m_user_d;

    logic [NUM_SRC-1:0]  req_np_s;
    logic                others_s;
    logic                prio_win_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_found_s;
    logic                ld_s;
    logic                acc_s;
    logic                sel_valid_s;
    logic                sel_last_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [KEEP_W-1:0]   sel_keep_s;
    logic [USER_W-1:0]   sel_user_s;

    assign req_np_s   = s_valid & ~PRIO_MASK;
    assign others_s   = |req_np_s;
    assign prio_win_s = s_valid[PRIO_IDX] & ((starve_cnt_q < STARVE_LIM) | ~others_s);
    assign ld_s       = ~m_valid_q | m_ready;

    rr_pick #(
        .N (NUM_SRC),
        .W (IDX_W)
    ) u_rr_pick (
        .req   (req_np_s),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // AND-OR mux of the granted source's slices.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = '0;
        sel_keep_s  = '0;
        sel_user_s  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_valid_s = sel_valid_s | (s_valid[i] & (grant_q == IDX_W'(i)));
            sel_last_s  = sel_last_s  | (s_last[i]  & (grant_q == IDX_W'(i)));
            sel_data_s  = sel_data_s  | (s_data[i*DATA_W +: DATA_W] & {DATA_W{grant_q == IDX_W'(i)}});
            sel_keep_s  = sel_keep_s  | (s_keep[i*KEEP_W +: KEEP_W] & {KEEP_W{grant_q == IDX_W'(i)}});
            sel_user_s  = sel_user_s  | (s_user[i*USER_W +: USER_W] & {USER_W{grant_q == IDX_W'(i)}});
        end
    end

    // Arbitration FSM next state and output-stage load/drain.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        m_user_d     = m_user_q;
        s_ready      = '0;
        acc_s        = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (prio_win_s || pick_found_s) begin
                    state_d = ARB_XFER;
                    if (prio_win_s) begin
                        grant_d = PRIO_SEL;
                        if (!others_s) begin
                            starve_cnt_d = '0;
                        end else if (starve_cnt_q < STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + CNT_W'(1);
                        end else begin
                            starve_cnt_d = STARVE_LIM;
                        end
                    end else begin
                        grant_d      = pick_idx_s;
                        rr_ptr_d     = wrap_inc(pick_idx_s, LAST_SRC);
                        starve_cnt_d = '0;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_XFER: begin
                s_ready = ld_s ? (NUM_SRC'(1) << grant_q) : '0;
                acc_s   = sel_valid_s & ld_s;
                if (acc_s && sel_last_s) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_XFER;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // Output register holds while stalled; drains even after the packet ends.
        if (acc_s) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data_s;
            m_keep_d  = sel_keep_s;
            m_last_d  = sel_last_s;
            m_user_d  = sel_user_s;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // State, arbitration bookkeeping and output stage registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            m_user_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_user_q     <= m_user_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_keep    = m_keep_q;
    assign m_last    = m_last_q;
    assign m_user    = m_user_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == ARB_XFER);
endmodule
